imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter INSTRUCTION_SIZE, default 16, instruction word width in bits.
REQ-002 The block SHALL have parameter INSTRUCTION_ADDR_SIZE, default 10, address width; depth = 2^INSTRUCTION_ADDR_SIZE words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have port fetch_en  input  1  fetch request.
REQ-006 The block SHALL have port fetch_addr  input  INSTRUCTION_ADDR_SIZE  fetch word address.
REQ-007 The block SHALL have port fetch_data  output  INSTRUCTION_SIZE  registered fetched instruction.
REQ-008 The block SHALL have port fetch_valid  output  1  fetch_data valid this cycle.
REQ-009 The block SHALL have port load_start  input  1  begin program load.
REQ-010 The block SHALL have port load_base  input  INSTRUCTION_ADDR_SIZE  first load address.
REQ-011 The block SHALL have port load_len  input  INSTRUCTION_ADDR_SIZE+1  words to load, 0..depth.
REQ-012 The block SHALL have port load_data  input  INSTRUCTION_SIZE  load word.
REQ-013 The block SHALL have port load_valid  input  1  load_data present.
REQ-014 The block SHALL have port load_ready  output  1  block accepts load words.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port load_done  output  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have exactly three states: CLEAR, IDLE and LOAD.
REQ-018 In CLEAR, the block SHALL write zero to one word per cycle at addresses 0..depth-1, then enter IDLE; this takes depth cycles.
REQ-019 In IDLE, fetch_en=1 SHALL cause fetch_data=mem[fetch_addr] and fetch_valid=1 on the next cycle; latency is 1.
REQ-020 When no fetch is accepted, fetch_valid SHALL be 0 the next cycle and fetch_data SHALL hold its previous value.
REQ-021 fetch_en SHALL be ignored in CLEAR and LOAD.
REQ-022 In IDLE, load_start=1 with load_len>0 SHALL latch the pointer to load_base and the counter to load_len, then enter LOAD.
REQ-023 In IDLE, load_start=1 with load_len=0 SHALL pulse load_done the next cycle and remain in IDLE.
REQ-024 In LOAD, load_ready SHALL be 1; in all other states it SHALL be 0.
REQ-025 Each load_valid&load_ready cycle SHALL write mem[ptr]=load_data, increment ptr modulo depth (wrap-around), and decrement the counter.
REQ-026 On acceptance of the final word, the block SHALL return to IDLE and pulse load_done for one cycle (the cycle after the last write).
REQ-027 load_valid=0 in LOAD SHALL stall the load with no write and no timeout.
REQ-028 load_start SHALL be ignored in CLEAR and LOAD.
REQ-029 If fetch_en and load_start are both high in IDLE, the block SHALL serve the fetch with pre-load contents and also start the load.
REQ-030 A fetch to an address written earlier in the same load SHALL return the new word.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state CLEAR with clear pointer 0, fetch_valid=0, fetch_data=0, load_ready=0, load_done=0 and busy=1, from any state, including mid-LOAD.
REQ-032 A load interrupted by reset SHALL be discarded; the memory SHALL be fully re-zeroed before IDLE.

Structure
REQ-033 A shared package SHALL hold the state enum (CLEAR/IDLE/LOAD) and the default width/address constants.
REQ-034 The storage SHALL be a sub-module imem_array: a synchronous RAM with one write port and one registered read port, parametrised by the same two widths.

Verification
REQ-035 Post-reset (INSTRUCTION_ADDR_SIZE=4): busy=1 for 16 cycles, then 0; fetching any address returns 0x0000 with fetch_valid one cycle later.
REQ-036 Load base=2, len=3, words 0x8101/0x8201/0x8406 → load_done pulses once; fetches at 2, 3, 4 return those words and address 5 returns 0.
REQ-037 Wrap-around: base=15, len=2, words 0xAAAA/0xBBBB → mem[15]=0xAAAA and mem[0]=0xBBBB.
REQ-038 Load with load_valid gaps of 3 idle cycles → no extra writes, and the completion timing matches REQ-026; fetch_en during LOAD → fetch_valid stays 0.
REQ-039 Simultaneous fetch_en (addr 2, holds 0x1111) and load_start writing 0x2222 at 2 → fetch returns 0x1111; a later fetch returns 0x2222.
REQ-040 rst_n asserted mid-load after 1 of 4 words → CLEAR re-entered; after 16 cycles all addresses read 0 and load_done never pulses.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared widths and FSM state encoding for the instruction-memory loader.
package imem_loader_pkg;

    localparam int DEF_INSTRUCTION_SIZE      = 16;
    localparam int DEF_INSTRUCTION_ADDR_SIZE = 10;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/imem_array.sv
// Synchronous single-write / single-registered-read instruction RAM.
// Read data holds its last value when no read is issued; only the read register is reset.
module imem_array
    import imem_loader_pkg::*;
#(
    parameter int INSTRUCTION_SIZE      = DEF_INSTRUCTION_SIZE,
    parameter int INSTRUCTION_ADDR_SIZE = DEF_INSTRUCTION_ADDR_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] waddr,
    input  logic [INSTRUCTION_SIZE-1:0]      wdata,
    input  logic                             re,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] raddr,
    output logic [INSTRUCTION_SIZE-1:0]      rdata
);

    localparam int DEPTH = 1 << INSTRUCTION_ADDR_SIZE;

    logic [INSTRUCTION_SIZE-1:0] mem [DEPTH];
    logic [INSTRUCTION_SIZE-1:0] rdata_q;
    logic [INSTRUCTION_SIZE-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with power-on clear, 1-cycle fetch port and a streaming program loader.
// Fetches are served only in IDLE; load words are accepted one per cycle while in LOAD.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INSTRUCTION_SIZE      = DEF_INSTRUCTION_SIZE,
    parameter int INSTRUCTION_ADDR_SIZE = DEF_INSTRUCTION_ADDR_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             fetch_en,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] fetch_addr,
    output logic [INSTRUCTION_SIZE-1:0]      fetch_data,
    output logic                             fetch_valid,
    input  logic                             load_start,
    input  logic [INSTRUCTION_ADDR_SIZE-1:0] load_base,
    input  logic [INSTRUCTION_ADDR_SIZE:0]   load_len,
    input  logic [INSTRUCTION_SIZE-1:0]      load_data,
    input  logic                             load_valid,
    output logic                             load_ready,
    output logic                             busy,
    output logic                             load_done
);

    localparam int AW = INSTRUCTION_ADDR_SIZE;
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            fetch_valid_q, fetch_valid_d;

    logic                        mem_we;
    logic                        mem_re;
    logic [AW-1:0]               mem_waddr;
    logic [INSTRUCTION_SIZE-1:0] mem_wdata;

    always_comb begin
        state_d       = state_q;
        clr_ptr_d     = clr_ptr_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        fetch_valid_d = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_waddr     = ptr_q;
        mem_wdata     = load_data;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (&clr_ptr_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // The load's first write lands a cycle later, so a same-cycle fetch sees old contents.
                if (fetch_en) begin
                    mem_re        = 1'b1;
                    fetch_valid_d = 1'b1;
                end
                if (load_start) begin
                    if (load_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = load_base;
                        cnt_d   = load_len;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_CLEAR;
            clr_ptr_q     <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            done_q        <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    imem_array #(
        .INSTRUCTION_SIZE      (INSTRUCTION_SIZE),
        .INSTRUCTION_ADDR_SIZE (INSTRUCTION_ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we & rst_n),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (fetch_addr),
        .rdata (fetch_data)
    );

    assign fetch_valid = fetch_valid_q;
    assign load_done   = done_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a 16-word memory.
module tb_imem_loader;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_data;
    logic          fetch_valid;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_len;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          load_ready;
    logic          busy;
    logic          load_done;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] wq [4];

    always #5 clk = ~clk;

    imem_loader #(
        .INSTRUCTION_SIZE      (DW),
        .INSTRUCTION_ADDR_SIZE (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_len    (load_len),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .busy        (busy),
        .load_done   (load_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = a;
        step();
        fetch_en = 1'b0;
        chk("fetch_vld", {31'd0, fetch_valid}, 32'd1);
        chk("fetch_dat", {16'd0, fetch_data}, {16'd0, exp});
    endtask

    // Count cycles until busy drops, with fetch_en held high to show it is ignored.
    task automatic clear_count(output int n, output bit saw_done);
        n          = 0;
        saw_done   = 1'b0;
        fetch_en   = 1'b1;
        fetch_addr = 4'd3;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
            if (load_done !== 1'b0) saw_done = 1'b1;
            chk("fetch_in_clear", {31'd0, fetch_valid}, 32'd0);
        end
        fetch_en = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] base, input int len, input int gap,
                           input bit co_fetch, input logic [DW-1:0] co_exp);
        load_start = 1'b1;
        load_base  = base;
        load_len   = len[AW:0];
        if (co_fetch) begin
            fetch_en   = 1'b1;
            fetch_addr = base;
        end
        step();
        load_start = 1'b0;
        fetch_en   = 1'b0;
        if (co_fetch) begin
            chk("co_fetch_vld", {31'd0, fetch_valid}, 32'd1);
            chk("co_fetch_dat", {16'd0, fetch_data}, {16'd0, co_exp});
        end
        chk("load_rdy", {31'd0, load_ready}, 32'd1);
        chk("busy_load", {31'd0, busy}, 32'd1);
        for (int i = 0; i < len; i++) begin
            for (int g = 0; g < gap; g++) begin
                fetch_en   = 1'b1;
                fetch_addr = base;
                step();
                fetch_en = 1'b0;
                chk("fetch_in_load", {31'd0, fetch_valid}, 32'd0);
                chk("done_gap", {31'd0, load_done}, 32'd0);
                chk("rdy_gap", {31'd0, load_ready}, 32'd1);
            end
            load_valid = 1'b1;
            load_data  = wq[i];
            step();
            load_valid = 1'b0;
            if (i < len - 1) chk("done_early", {31'd0, load_done}, 32'd0);
        end
        chk("done_pulse", {31'd0, load_done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("rdy_after", {31'd0, load_ready}, 32'd0);
        step();
        chk("done_once", {31'd0, load_done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        bit saw;

        rst_n      = 1'b0;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_len   = '0;
        load_data  = '0;
        load_valid = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_fvld", {31'd0, fetch_valid}, 32'd0);
        chk("rst_fdat", {16'd0, fetch_data}, 32'd0);
        chk("rst_rdy", {31'd0, load_ready}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);

        rst_n = 1'b1;
        clear_count(n, saw);
        chk("clear_cycles", n, 32'd16);
        chk("clear_no_done", {31'd0, saw}, 32'd0);

        fetch(4'd0, 16'h0000);
        fetch(4'd9, 16'h0000);
        fetch(4'd15, 16'h0000);
        step();
        chk("fvld_drop", {31'd0, fetch_valid}, 32'd0);

        // Zero-length load completes immediately without leaving IDLE.
        load_start = 1'b1;
        load_len   = '0;
        load_base  = 4'd6;
        step();
        load_start = 1'b0;
        chk("zlen_done", {31'd0, load_done}, 32'd1);
        chk("zlen_busy", {31'd0, busy}, 32'd0);
        step();
        chk("zlen_done_once", {31'd0, load_done}, 32'd0);

        wq[0] = 16'h8101; wq[1] = 16'h8201; wq[2] = 16'h8406; wq[3] = 16'h0000;
        do_load(4'd2, 3, 0, 1'b0, 16'h0000);
        fetch(4'd2, 16'h8101);
        fetch(4'd3, 16'h8201);
        chk("fdat_hold_pre", {16'd0, fetch_data}, 32'h8201);
        step();
        chk("fdat_hold", {16'd0, fetch_data}, 32'h8201);
        chk("fvld_hold", {31'd0, fetch_valid}, 32'd0);
        fetch(4'd4, 16'h8406);
        fetch(4'd5, 16'h0000);

        wq[0] = 16'hAAAA; wq[1] = 16'hBBBB;
        do_load(4'd15, 2, 0, 1'b0, 16'h0000);
        fetch(4'd15, 16'hAAAA);
        fetch(4'd0, 16'hBBBB);
        fetch(4'd1, 16'h0000);

        wq[0] = 16'h1234; wq[1] = 16'h5678; wq[2] = 16'h9ABC;
        do_load(4'd8, 3, 3, 1'b0, 16'h0000);
        fetch(4'd7, 16'h0000);
        fetch(4'd8, 16'h1234);
        fetch(4'd9, 16'h5678);
        fetch(4'd10, 16'h9ABC);
        fetch(4'd11, 16'h0000);

        wq[0] = 16'h1111;
        do_load(4'd2, 1, 0, 1'b0, 16'h0000);
        wq[0] = 16'h2222;
        do_load(4'd2, 1, 0, 1'b1, 16'h1111);
        fetch(4'd2, 16'h2222);

        // Reset after one of four words has been written.
        load_start = 1'b1;
        load_base  = 4'd4;
        load_len   = 5'd4;
        step();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        step();
        chk("mid_rdy", {31'd0, load_ready}, 32'd1);
        load_data = 16'hBEEF;
        rst_n     = 1'b0;
        step();
        load_valid = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd1);
        chk("mid_rst_rdy", {31'd0, load_ready}, 32'd0);
        chk("mid_rst_done", {31'd0, load_done}, 32'd0);
        chk("mid_rst_fvld", {31'd0, fetch_valid}, 32'd0);
        chk("mid_rst_fdat", {16'd0, fetch_data}, 32'd0);
        rst_n = 1'b1;
        clear_count(n, saw);
        chk("reclear_cycles", n, 32'd16);
        chk("reclear_no_done", {31'd0, saw}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            fetch(a[AW-1:0], 16'h0000);
            chk("post_rst_done", {31'd0, load_done}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
